// File: rtl/read_mem_sequencer.sv
// rtl/read_mem_sequencer.sv - word-at-a-time read sequencer between controller and read memory
//
// Purpose: a start pulse latches a byte base address and a word count. The
// block then walks word-aligned addresses and registers each 4-byte word. It
// hands every word downstream with valid/ready, and pulses done once the
// request completes.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous active-high reset
//   start      1-cycle request, sampled only while idle
//   base_addr  byte address of first word (low 2 bits ignored)
//   num_words  number of 32-bit words to read (0 = empty request)
//   mem_addr   word-aligned byte address to the memory
//   mem_data   combinational memory word, [0] is the MSB byte
//   out_data   registered word, same byte order as mem_data
//   out_valid  out_data holds a word for downstream
//   out_ready  downstream accepts the word when out_valid && out_ready
//   busy       high in every state except idle
//   done       1-cycle pulse at the end of each request

module read_mem_sequencer #(
    parameter int NO_BITS  = 8,
    parameter int LEN_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NO_BITS-1:0]  base_addr,
    input  logic [LEN_BITS-1:0] num_words,
    output logic [NO_BITS-1:0]  mem_addr,
    input  logic [0:3][7:0]     mem_data,
    output logic [0:3][7:0]     out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        VALID   = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    state_t              state;
    logic [LEN_BITS-1:0] cnt;

    // The byte offset inside a word never reaches the memory.
    logic unused_base_lsbs;
    assign unused_base_lsbs = ^base_addr[1:0];

    // mem_addr is the address register itself; it is only meaningful in FETCH
    // and while a word is held, and simply wraps modulo 2^NO_BITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (num_words != '0) begin
                            mem_addr <= {base_addr[NO_BITS-1:2], 2'b00};
                            cnt      <= num_words;
                            state    <= FETCH;
                        end else begin
                            // Empty request: finish without touching memory.
                            done  <= 1'b1;
                            state <= DONE_ST;
                        end
                    end
                end

                FETCH: begin
                    out_data  <= mem_data;
                    out_valid <= 1'b1;
                    state     <= VALID;
                end

                VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= cnt - LEN_BITS'(1);
                        mem_addr  <= mem_addr + NO_BITS'(4);
                        if (cnt == LEN_BITS'(1)) begin
                            done  <= 1'b1;
                            state <= DONE_ST;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end

                DONE_ST: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_mem_sequencer.sv
// tb/tb_read_mem_sequencer.sv - self-checking bench for read_mem_sequencer

module tb_read_mem_sequencer;

    logic           clk;
    logic           rst;
    logic           start;
    logic [7:0]     base_addr;
    logic [7:0]     num_words;
    logic [7:0]     mem_addr;
    logic [0:3][7:0] mem_data;
    logic [0:3][7:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           done;

    read_mem_sequencer #(.NO_BITS(8), .LEN_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    logic [31:0] mem [64];
    assign mem_data = mem[mem_addr[7:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a request becomes a list of expected word
    // addresses; a word appears one cycle after it is due and stays until taken.
    bit          m_started = 0;
    bit          m_busy    = 0;
    bit          m_valid   = 0;
    bit          m_wait    = 0;
    bit          m_done    = 0;
    logic [31:0] m_data    = '0;
    int          exp_q[$];

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          done_cnt = 0;

    always @(posedge clk) begin
        m_started = 1;
        if (rst) begin
            m_busy = 0; m_valid = 0; m_wait = 0; m_done = 0; m_data = '0;
            exp_q.delete();
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1;
                if (num_words == 0) begin
                    m_done = 1;
                end else begin
                    for (int i = 0; i < int'(num_words); i++)
                        exp_q.push_back(((int'(base_addr) & 252) + 4 * i) % 256);
                    m_wait = 1;
                end
            end
        end else if (m_wait) begin
            m_wait  = 0;
            m_valid = 1;
            m_data  = mem[exp_q[0] / 4];
        end else if (m_valid && out_ready) begin
            m_valid = 0;
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_done = 1;
            else                   m_wait = 1;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("done", 32'(done), 32'(m_done));
            chk("busy", 32'(busy), 32'(m_busy));
            if (m_valid) begin
                chk("out_data", out_data, m_data);
                chk("mem_addr_held", 32'(mem_addr), 32'(exp_q[0]));
            end
            if (m_wait) chk("mem_addr_fetch", 32'(mem_addr), 32'(exp_q[0]));
            if (!rst && out_valid && out_ready) begin
                log_addr.push_back(32'(mem_addr));
                log_data.push_back(out_data);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] n);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            if (!busy) break;
            tick();
        end
        if (k == 300) chk({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    int d0;

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b1;
        for (int i = 0; i < 64; i++)
            mem[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)} ^ 32'h5A00_00A5;
        mem[0] = 32'h11223344;

        // 1: reset
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        tick();

        // 2: basic three-word request
        clear_log(); d0 = done_cnt;
        do_start(8'h00, 8'd3);
        wait_idle("basic");
        chk("basic_beats", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            chk("basic_a0", log_addr[0], 32'h00);
            chk("basic_a1", log_addr[1], 32'h04);
            chk("basic_a2", log_addr[2], 32'h08);
            chk("basic_d0", log_data[0], 32'h11223344);
        end
        chk("basic_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 3: backpressure on beat 1, plus a start while busy that must be dropped
        clear_log();
        out_ready = 1'b0;
        do_start(8'h10, 8'd3);
        tick();
        do_start(8'h80, 8'd5);
        repeat (4) tick();
        out_ready = 1'b1;
        wait_idle("bp");
        chk("bp_beats", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            chk("bp_a0", log_addr[0], 32'h10);
            chk("bp_a2", log_addr[2], 32'h18);
            chk("bp_d1", log_data[1], mem[5]);
        end
        tick();
        chk("bp_no_queue", 32'(busy), 32'd0);

        // 4: alignment and wrap
        clear_log();
        do_start(8'hFE, 8'd2);
        wait_idle("wrap");
        chk("wrap_beats", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk("wrap_a0", log_addr[0], 32'hFC);
            chk("wrap_a1", log_addr[1], 32'h00);
            chk("wrap_d1", log_data[1], 32'h11223344);
        end

        // 5: zero length
        clear_log(); d0 = done_cnt;
        do_start(8'h40, 8'd0);
        chk("zero_done_hi", 32'(done), 32'd1);
        chk("zero_valid", 32'(out_valid), 32'd0);
        tick();
        chk("zero_done_lo", 32'(done), 32'd0);
        chk("zero_idle", 32'(busy), 32'd0);
        chk("zero_beats", 32'(log_addr.size()), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

        // random ready pattern
        clear_log();
        do_start(8'h81, 8'd6);
        for (int k = 0; k < 200 && busy; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        wait_idle("rand");
        chk("rand_beats", 32'(log_addr.size()), 32'd6);
        if (log_addr.size() == 6) chk("rand_a5", log_addr[5], 32'h94);

        // 6: reset during beat 2 of 4, then a fresh request
        clear_log(); d0 = done_cnt;
        do_start(8'h20, 8'd4);
        for (int k = 0; k < 50; k++) begin
            if (log_addr.size() == 1 && out_valid) break;
            tick();
        end
        chk("mid_reached_beat2", 32'(log_addr.size()), 32'd1);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        repeat (3) tick();
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
        clear_log();
        do_start(8'h40, 8'd2);
        wait_idle("after_rst");
        chk("after_rst_beats", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk("after_rst_a0", log_addr[0], 32'h40);
            chk("after_rst_a1", log_addr[1], 32'h44);
        end
        chk("after_rst_done", 32'(done_cnt - d0), 32'd1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
